// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: synchronises the data line, measures high pulse widths
// to recover bits, and assembles GRB pixels into per-frame indexed outputs.
module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 50_000_000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        di_i,
  output logic                        pixel_valid_o,
  output logic [$clog2(NUM_LEDS)-1:0] address_o,
  output logic [7:0]                  red_o,
  output logic [7:0]                  green_o,
  output logic [7:0]                  blue_o,
  output logic                        frame_done_o,
  output logic [$clog2(NUM_LEDS):0]   pixel_count_o,
  output logic                        error_o,
  output logic                        busy_o
);

  localparam int CYCLE_COUNT = SYSTEM_CLOCK / 800_000;
  localparam int THRESH      = (48 * CYCLE_COUNT) / 100;
  localparam int STUCK       = 2 * CYCLE_COUNT;
  localparam int RESET_COUNT = SYSTEM_CLOCK / 20_000;
  localparam int PW          = $clog2(NUM_LEDS) + 1;
  localparam int CW          = $clog2(RESET_COUNT + 1);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  logic          s1, s2, s3;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [22:0]   shreg;
  logic [4:0]    bit_cnt;
  logic [PW-1:0] pix_cnt;
  logic          rise, fall, bit_val;
  logic [23:0]   word;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign bit_val = (cnt > CW'(THRESH));
  assign word    = {shreg, bit_val};
  assign busy_o  = (state != S_IDLE);

  // One counter serves as the low-gap counter (SYNC/LOW) and the high-width counter (HIGH).
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      state         <= S_SYNC;
      cnt           <= '0;
      shreg         <= '0;
      bit_cnt       <= '0;
      pix_cnt       <= '0;
      pixel_valid_o <= 1'b0;
      frame_done_o  <= 1'b0;
      error_o       <= 1'b0;
      address_o     <= '0;
      pixel_count_o <= '0;
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
    end else begin
      s1            <= di_i;
      s2            <= s1;
      s3            <= s2;
      pixel_valid_o <= 1'b0;
      frame_done_o  <= 1'b0;
      error_o       <= 1'b0;
      if (pixel_valid_o) address_o <= address_o + 1'b1;

      case (state)
        S_SYNC: begin
          if (s2) cnt <= '0;
          else if (cnt == CW'(RESET_COUNT - 1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        S_IDLE: begin
          if (rise) begin
            state <= S_HIGH;
            cnt   <= CW'(1);
          end
        end
        S_HIGH: begin
          if (fall) begin
            shreg <= word[22:0];
            state <= S_LOW;
            cnt   <= '0;
            // The 24th bit is folded in directly so the pixel appears on this same edge.
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pix_cnt == PW'(NUM_LEDS)) error_o <= 1'b1;
              else begin
                green_o       <= word[23:16];
                red_o         <= word[15:8];
                blue_o        <= word[7:0];
                pixel_valid_o <= 1'b1;
                pix_cnt       <= pix_cnt + 1'b1;
              end
            end else bit_cnt <= bit_cnt + 1'b1;
          end else if (cnt == CW'(STUCK - 1)) begin
            // Line stuck high: abandon the frame and resynchronise.
            error_o   <= 1'b1;
            bit_cnt   <= '0;
            pix_cnt   <= '0;
            address_o <= '0;
            state     <= S_SYNC;
            cnt       <= '0;
          end else cnt <= cnt + 1'b1;
        end
        S_LOW: begin
          if (rise) begin
            state <= S_HIGH;
            cnt   <= CW'(1);
          end else if (cnt == CW'(RESET_COUNT - 1)) begin
            frame_done_o  <= 1'b1;
            pixel_count_o <= pix_cnt;
            error_o       <= (bit_cnt != '0);
            pix_cnt       <= '0;
            address_o     <= '0;
            bit_cnt       <= '0;
            state         <= S_IDLE;
            cnt           <= '0;
          end else if (cnt != CW'(RESET_COUNT)) cnt <= cnt + 1'b1;
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives WS2812 waveforms at 50 MHz and compares decoded
// pixels, frame strobes and errors against expectations derived from the sent data.
module tb_ws2812_rx;
  localparam int NUM_LEDS = 8;
  localparam int AW       = $clog2(NUM_LEDS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          di  = 1'b0;
  logic          pixel_valid, frame_done, error, busy;
  logic [AW-1:0] address;
  logic [7:0]    red, green, blue;
  logic [AW:0]   pixel_count;

  ws2812_rx #(.NUM_LEDS(NUM_LEDS), .SYSTEM_CLOCK(50_000_000)) dut (
    .clk_i(clk), .reset_i(rst), .di_i(di),
    .pixel_valid_o(pixel_valid), .address_o(address),
    .red_o(red), .green_o(green), .blue_o(blue),
    .frame_done_o(frame_done), .pixel_count_o(pixel_count),
    .error_o(error), .busy_o(busy)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: every strobe seen on the outputs, sampled mid-cycle.
  logic [AW+23:0] pv_q[$];
  int unsigned    pv_cyc, err_cyc, fall_cyc;
  int             err_n, fd_n;
  logic [AW:0]    fd_cnt;
  logic           fd_err;

  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_valid) begin
        pv_q.push_back({address, green, red, blue});
        pv_cyc = cyc;
      end
      if (error) begin
        err_n++;
        err_cyc = cyc;
      end
      if (frame_done) begin
        fd_n++;
        fd_cnt = pixel_count;
        fd_err = error;
      end
    end
  end

  task automatic clear_mon;
    pv_q.delete();
    err_n = 0; fd_n = 0; fd_cnt = '0; fd_err = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    di = 1'b1;
    repeat (b ? 32 : 16) @(negedge clk);
    di = 1'b0;
    fall_cyc = cyc;
    repeat (b ? 30 : 46) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) drive_bit(w[i]);
  endtask

  task automatic gap(input int n);
    di = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; di = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_reset;
    di = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({pixel_valid, frame_done, error, address, pixel_count, red, green, blue} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %0h want 0",
                      {pixel_valid, frame_done, error, address, pixel_count, red, green, blue});
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    rst = 1'b0;
    clear_mon();
    gap(100);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL sync_busy_early: got %b want 1", busy); end
  endtask

  task automatic test_single;
    int unsigned last_fall;
    do_reset();
    gap(2600);
    send_pixel(24'hA53C0F);
    last_fall = fall_cyc;
    gap(3000);
    total++;
    if (pv_q.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", pv_q.size()); end
    else begin
      total++;
      if (pv_q[0] !== {AW'(0), 24'hA53C0F}) begin
        bad++; $display("FAIL single_pixel: got %0h want %0h", pv_q[0], {AW'(0), 24'hA53C0F});
      end
      total++;
      if (pv_cyc - last_fall != 3) begin
        bad++; $display("FAIL single_latency: got %0d want 3", pv_cyc - last_fall);
      end
    end
    total++;
    if (fd_n != 1 || fd_cnt !== (AW+1)'(1)) begin
      bad++; $display("FAIL single_frame: got n=%0d cnt=%0d want n=1 cnt=1", fd_n, fd_cnt);
    end
    total++;
    if (err_n != 0) begin bad++; $display("FAIL single_err: got %0d want 0", err_n); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_frames;
    int counts[2] = '{3, 9};
    logic [23:0] px[$];
    int exp_n;
    foreach (counts[k]) begin
      clear_mon();
      px.delete();
      for (int i = 0; i < counts[k]; i++) begin
        px.push_back(24'($urandom));
        send_pixel(px[i]);
      end
      gap(3000);
      exp_n = (counts[k] < NUM_LEDS) ? counts[k] : NUM_LEDS;
      total++;
      if (pv_q.size() != exp_n) begin
        bad++; $display("FAIL frame%0d_count: got %0d want %0d", k, pv_q.size(), exp_n);
      end
      for (int i = 0; i < exp_n && i < pv_q.size(); i++) begin
        total++;
        if (pv_q[i] !== {AW'(i), px[i]}) begin
          bad++; $display("FAIL frame%0d_pixel%0d: got %0h want %0h", k, i, pv_q[i], {AW'(i), px[i]});
        end
      end
      total++;
      if (err_n != counts[k] - exp_n) begin
        bad++; $display("FAIL frame%0d_err: got %0d want %0d", k, err_n, counts[k] - exp_n);
      end
      total++;
      if (fd_n != 1 || fd_cnt !== (AW+1)'(exp_n)) begin
        bad++; $display("FAIL frame%0d_done: got n=%0d cnt=%0d want n=1 cnt=%0d", k, fd_n, fd_cnt, exp_n);
      end
    end
  endtask

  task automatic test_partial;
    clear_mon();
    for (int i = 0; i < 12; i++) drive_bit(1'($urandom));
    gap(3000);
    total++;
    if (fd_n != 1 || fd_err !== 1'b1) begin
      bad++; $display("FAIL partial_done_err: got n=%0d err=%b want n=1 err=1", fd_n, fd_err);
    end
    total++;
    if (err_n != 1) begin bad++; $display("FAIL partial_err_count: got %0d want 1", err_n); end
    total++;
    if (fd_cnt !== '0) begin bad++; $display("FAIL partial_pixcount: got %0d want 0", fd_cnt); end
    total++;
    if (pv_q.size() != 0) begin bad++; $display("FAIL partial_pixels: got %0d want 0", pv_q.size()); end
  endtask

  task automatic test_stuck;
    int unsigned start;
    clear_mon();
    di = 1'b1;
    start = cyc;
    repeat (200) @(negedge clk);
    total++;
    if (err_n != 1) begin bad++; $display("FAIL stuck_err_count: got %0d want 1", err_n); end
    total++;
    if (err_cyc - start < 124 || err_cyc - start > 127) begin
      bad++; $display("FAIL stuck_err_time: got %0d want 124..127", err_cyc - start);
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL stuck_busy_high: got %b want 1", busy); end
    gap(1000);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL stuck_busy_sync: got %b want 1", busy); end
    gap(2000);
    total++;
    if (busy !== 1'b0 || fd_n != 0) begin
      bad++; $display("FAIL stuck_recover: got busy=%b fd=%0d want busy=0 fd=0", busy, fd_n);
    end
  endtask

  task automatic test_resync;
    logic [23:0] p;
    do_reset();
    gap(20);
    send_pixel(24'($urandom));
    send_pixel(24'($urandom));
    gap(3000);
    total++;
    if (pv_q.size() != 0 || fd_n != 0 || err_n != 0) begin
      bad++; $display("FAIL resync_ignored: got pv=%0d fd=%0d err=%0d want 0 0 0", pv_q.size(), fd_n, err_n);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL resync_idle: got %b want 0", busy); end
    p = 24'($urandom);
    send_pixel(p);
    gap(3000);
    total++;
    if (pv_q.size() != 1) begin bad++; $display("FAIL resync_count: got %0d want 1", pv_q.size()); end
    else begin
      total++;
      if (pv_q[0] !== {AW'(0), p}) begin
        bad++; $display("FAIL resync_pixel: got %0h want %0h", pv_q[0], {AW'(0), p});
      end
    end
    total++;
    if (fd_n != 1 || fd_cnt !== (AW+1)'(1)) begin
      bad++; $display("FAIL resync_done: got n=%0d cnt=%0d want n=1 cnt=1", fd_n, fd_cnt);
    end
  endtask

  task automatic test_reset_midframe;
    logic [23:0] px[2];
    clear_mon();
    send_pixel(24'($urandom) | 24'h808080);
    for (int i = 0; i < 10; i++) drive_bit(1'($urandom));
    total++;
    if (pv_q.size() != 1) begin bad++; $display("FAIL mid_first_pixel: got %0d want 1", pv_q.size()); end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({pixel_valid, frame_done, error, address, pixel_count, red, green, blue} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got %0h want 0",
                      {pixel_valid, frame_done, error, address, pixel_count, red, green, blue});
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_reset_busy: got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    gap(2600);
    foreach (px[i]) begin
      px[i] = 24'($urandom);
      send_pixel(px[i]);
    end
    gap(3000);
    total++;
    if (pv_q.size() != 2) begin bad++; $display("FAIL mid_after_count: got %0d want 2", pv_q.size()); end
    for (int i = 0; i < 2 && i < pv_q.size(); i++) begin
      total++;
      if (pv_q[i] !== {AW'(i), px[i]}) begin
        bad++; $display("FAIL mid_after_pixel%0d: got %0h want %0h", i, pv_q[i], {AW'(i), px[i]});
      end
    end
    total++;
    if (fd_n != 1 || fd_cnt !== (AW+1)'(2) || err_n != 0) begin
      bad++; $display("FAIL mid_after_done: got n=%0d cnt=%0d err=%0d want 1 2 0", fd_n, fd_cnt, err_n);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_frames();
    test_partial();
    test_stuck();
    test_resync();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
